sysex_patch_dump: RTL and testbench
===================================

// Module: sysex_patch_dump
// PURPOSE
//  Bus master for the synth-engine parameter bus. On request it walks every
//    osc, com, mat1 and mat2 parameter address.
//  For each address it asserts the group select and the read strobe, then
//    captures the byte that the engine drives.
//  It streams the patch out as a MIDI SysEx message over a byte valid/ready
//    link to the MIDI transmitter.
//  It sits between the engine's parameter registers and midi_tx.
// PARAMETERS
//  V_OSC        4     oscs per voice; osc and mat groups span V_OSC*16 addresses
//  COM_LEN      16    common-group addresses dumped (0..COM_LEN-1)
//  READ_CYCLES  2     clocks the read strobe is held high (>=1)
//  MFR_ID       8'h7D manufacturer ID byte
//  CMD_DUMP     8'h01 command byte after the device ID
// PORTS
//  sCLK_XVXENVS          in   1  system clock; all logic on posedge
//  iRST_N                in   1  async active-low reset
//  dev_id                in   7  SysEx device ID, sampled at start
//  dump_req              in   1  one-cycle start pulse; ignored while busy
//  dump_busy             out  1  high from accepted request to F7 handshake
//  adr                   out  7  parameter address
//  osc_sel               out  1  osc group select, one-hot with the other sels
//  com_sel               out  1  common group select
//  m1_sel                out  1  matrix 1 select
//  m2_sel                out  1  matrix 2 select
//  read                  out  1  read strobe; the engine latches on its rising edge
//  sysex_data_patch_send out  1  high during parameter cycles; enables engine bus drive
//  data                  in   8  shared parameter bus (this block never drives it)
//  tx_byte               out  8  SysEx byte to midi_tx
//  tx_valid              out  1  tx_byte valid
//  tx_ready              in   1  midi_tx accepts when tx_valid & tx_ready at posedge
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE, checksum=0.
//   Mid-dump reset aborts at once; no F7 is sent.
//  Message order:
//   F0, MFR_ID, {1'b0,dev_id}, CMD_DUMP, then for g=0..3 (osc,com,m1,m2):
//   group byte 8'h10+g, then per address 0..LEN_g-1:
//   hi nibble {4'h0,d[7:4]}, lo nibble {4'h0,d[3:0]};
//   then checksum, then F7.
//  LEN_g = V_OSC*16 for osc/m1/m2 and COM_LEN for com.
//   Unused addresses are dumped as read; the engine returns 0 for them.
//  FSM states: IDLE -> HDR(4 bytes) -> GRP -> ADR -> RD -> HI -> LO -> ADR|GRP|CSUM -> EOX -> IDLE.
//  ADR (1 clk): sel[g] and adr valid, read=0, sysex_data_patch_send=1.
//  RD (READ_CYCLES clk): read=1.
//   On the edge leaving RD, capture data into d_reg and drop read.
//  sel, adr and sysex_data_patch_send stay stable from ADR through LO.
//   All three deassert in GRP, HDR, CSUM and EOX.
//  HI/LO: present the nibble byte and wait for handshake.
//   After LO: next address; or, after the last address, GRP of g+1 (after g=3, CSUM).
//  Handshake:
//   tx_byte is stable while tx_valid=1.
//   tx_valid drops only the cycle after acceptance; it may re-assert on the next cycle.
//   A byte can be accepted in the same cycle tx_valid rises if tx_ready=1.
//   tx_ready low stalls indefinitely with no timeout.
//  Checksum:
//   chk = 7-bit sum of all group and nibble bytes.
//   CSUM byte = (7'h00 - chk) & 7'h7F, so payload+csum == 0 mod 128.
//   chk clears on dump start.
//  Every byte other than F0/F7 has bit7=0.
//  dev_id is registered at IDLE->HDR; later changes do not alter the message.
//  dump_req in the same cycle as the F7 acceptance is ignored (busy still high).
//   A new dump may start from the next cycle.
//  Byte total = 4 + 4 + 2*(3*V_OSC*16 + COM_LEN) + 2.
//   At defaults this is 426.
// STRUCTURE
//  Shared package synth_bus_pkg:
//   - enum grp_t {GRP_OSC, GRP_COM, GRP_M1, GRP_M2}
//   - SYSEX_SOX = 8'hF0, SYSEX_EOX = 8'hF7
//   - FSM state enum
//  One sub-module, sysex_tx_slot: a 1-entry byte holding register that owns
//   tx_byte/tx_valid and the checksum accumulate. The FSM loads it and waits on its empty flag.
//  The counters (adr, group, read-hold) live in the top.
// TESTING
//  Conditions: engine model with osc_lvl[0]=8'h40 and m_vol=8'h40; tx_ready=1; dev_id=7'h05.
//   Stimulus: one dump_req.
//   Required: first bytes F0 7D 05 01 10.
//   Osc adr 2 gives nibbles 04 00; the com group byte is 11; com adr 1 gives 04 00.
//   Exactly 426 bytes are sent, the last is F7, and busy drops the cycle after F7 is accepted.
//  Stimulus: mat_buf2[3][1]=8'hC5 (adr 8'h13 in m2).
//   Required: nibbles 0C 05 appear after group byte 13, at address slot 19.
//   The checksum makes the payload sum mod 128 equal 0.
//  Stimulus: tx_ready toggled pseudo-randomly, including held low for 50 clk mid-HI.
//   Required: byte stream identical to the tx_ready=1 run.
//   tx_byte never changes while tx_valid=1 and not accepted.
//  Stimulus: READ_CYCLES=3.
//   Required: read is high exactly 3 clk per address and sel/adr are stable 1 clk before read rises.
//   Check the sel one-hot assertion throughout.
//  Stimulus: iRST_N asserted while in m1 group RD state.
//   Required: all outputs 0 immediately and no F7.
//   A following dump_req produces a full, correct 426-byte dump.
//  Stimulus: dump_req pulsed during busy, and again on the F7 acceptance cycle.
//   Required: both ignored and only one message is sent.
//   A dump_req one cycle later starts a new dump.

Source files
------------

// File: rtl/synth_bus_pkg.sv
// Shared types and constants for the synth-engine parameter bus and the SysEx dump master.
package synth_bus_pkg;

    typedef enum logic [1:0] {
        GRP_OSC = 2'd0,
        GRP_COM = 2'd1,
        GRP_M1  = 2'd2,
        GRP_M2  = 2'd3
    } grp_t;

    localparam logic [7:0] SYSEX_SOX = 8'hF0;
    localparam logic [7:0] SYSEX_EOX = 8'hF7;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_HDR  = 4'd1,
        ST_GRP  = 4'd2,
        ST_ADR  = 4'd3,
        ST_RD   = 4'd4,
        ST_HI   = 4'd5,
        ST_LO   = 4'd6,
        ST_CSUM = 4'd7,
        ST_EOX  = 4'd8
    } state_t;

    // Negated 7-bit sum so that payload plus checksum is 0 mod 128.
    function automatic logic [6:0] csum_byte(input logic [6:0] chk);
        return 7'h00 - chk;
    endfunction

    function automatic logic [3:0] grp_onehot(input grp_t grp);
        return 4'b0001 << grp;
    endfunction

endpackage

// File: rtl/sysex_tx_slot.sv
// One-entry byte holding register toward midi_tx; also accumulates the SysEx checksum.
module sysex_tx_slot (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_acc,
    input  logic       i_clr,
    input  logic       i_ready,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_empty,
    output logic       o_accept,
    output logic [6:0] o_chk
);

    logic [7:0] r_byte;
    logic       r_valid;
    logic [6:0] r_chk;

    // Byte holding register: loaded only when empty, released by the handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_byte  <= i_byte;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Checksum accumulator over group and nibble bytes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chk <= 7'h00;
        end else if (i_clr) begin
            r_chk <= 7'h00;
        end else if (i_load && i_acc) begin
            r_chk <= r_chk + i_byte[6:0];
        end else begin
            r_chk <= r_chk;
        end
    end

    assign o_byte   = r_byte;
    assign o_valid  = r_valid;
    assign o_empty  = !r_valid;
    assign o_accept = r_valid && i_ready;
    assign o_chk    = r_chk;

endmodule

// File: rtl/sysex_patch_dump.sv
// Parameter-bus master that reads every osc/com/mat1/mat2 address and streams
// the patch as a MIDI SysEx dump over a byte valid/ready link.
module sysex_patch_dump
    import synth_bus_pkg::*;
#(
    parameter int         V_OSC       = 4,
    parameter int         COM_LEN     = 16,
    parameter int         READ_CYCLES = 2,
    parameter logic [7:0] MFR_ID      = 8'h7D,
    parameter logic [7:0] CMD_DUMP    = 8'h01
) (
    input  logic       sCLK_XVXENVS,
    input  logic       iRST_N,
    input  logic [6:0] dev_id,
    input  logic       dump_req,
    output logic       dump_busy,
    output logic [6:0] adr,
    output logic       osc_sel,
    output logic       com_sel,
    output logic       m1_sel,
    output logic       m2_sel,
    output logic       read,
    output logic       sysex_data_patch_send,
    input  logic [7:0] data,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int              RD_W     = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;
    localparam logic [RD_W-1:0] RD_LAST  = RD_W'(READ_CYCLES - 1);
    localparam logic [6:0]      GRP_LAST = 7'(V_OSC * 16 - 1);
    localparam logic [6:0]      COM_LAST = 7'(COM_LEN - 1);

    state_t          r_state, w_state_nxt;
    grp_t            r_grp, w_grp_nxt;
    logic [6:0]      r_adr, w_adr_nxt;
    logic [1:0]      r_hdr, w_hdr_nxt;
    logic [RD_W-1:0] r_rd, w_rd_nxt;
    logic [7:0]      r_d;
    logic [6:0]      r_dev;
    logic            r_busy, r_read, r_send;
    logic [6:0]      r_adr_o;
    logic [3:0]      r_sel;

    logic            w_start, w_load, w_acc, w_tx_st, w_accept, w_empty, w_bus_act;
    logic [7:0]      w_byte;
    logic [6:0]      w_chk, w_last;

    assign w_last    = (r_grp == GRP_COM) ? COM_LAST : GRP_LAST;
    assign w_bus_act = (w_state_nxt == ST_ADR) || (w_state_nxt == ST_RD) ||
                       (w_state_nxt == ST_HI)  || (w_state_nxt == ST_LO);

    // Next-state and walk-counter logic; byte states advance on handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_grp_nxt   = r_grp;
        w_adr_nxt   = r_adr;
        w_hdr_nxt   = r_hdr;
        w_rd_nxt    = r_rd;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dump_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_HDR;
                    w_hdr_nxt   = 2'd0;
                    w_grp_nxt   = GRP_OSC;
                    w_adr_nxt   = 7'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (w_accept && (r_hdr == 2'd3)) begin
                    w_state_nxt = ST_GRP;
                end else if (w_accept) begin
                    w_hdr_nxt = r_hdr + 2'd1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_GRP: begin
                if (w_accept) begin
                    w_state_nxt = ST_ADR;
                    w_adr_nxt   = 7'd0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_ADR: begin
                w_state_nxt = ST_RD;
                w_rd_nxt    = {RD_W{1'b0}};
            end
            ST_RD: begin
                if (r_rd == RD_LAST) begin
                    w_state_nxt = ST_HI;
                end else begin
                    w_rd_nxt = r_rd + RD_W'(1);
                end
            end
            ST_HI: begin
                if (w_accept) begin
                    w_state_nxt = ST_LO;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_LO: begin
                if (w_accept && (r_adr != w_last)) begin
                    w_adr_nxt   = r_adr + 7'd1;
                    w_state_nxt = ST_ADR;
                end else if (w_accept && (r_grp != GRP_M2)) begin
                    w_adr_nxt   = 7'd0;
                    w_grp_nxt   = grp_t'(r_grp + 2'd1);
                    w_state_nxt = ST_GRP;
                end else if (w_accept) begin
                    w_adr_nxt   = 7'd0;
                    w_state_nxt = ST_CSUM;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_CSUM: begin
                if (w_accept) begin
                    w_state_nxt = ST_EOX;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_EOX: begin
                if (w_accept) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Byte presented to the tx slot in each byte-emitting state.
    always_comb begin
        w_byte  = 8'h00;
        w_acc   = 1'b0;
        w_tx_st = 1'b1;
        case (r_state)
            ST_HDR: begin
                case (r_hdr)
                    2'd0:    w_byte = SYSEX_SOX;
                    2'd1:    w_byte = MFR_ID;
                    2'd2:    w_byte = {1'b0, r_dev};
                    default: w_byte = CMD_DUMP;
                endcase
            end
            ST_GRP:  begin w_byte = {6'b000100, r_grp};  w_acc = 1'b1; end
            ST_HI:   begin w_byte = {4'h0, r_d[7:4]};    w_acc = 1'b1; end
            ST_LO:   begin w_byte = {4'h0, r_d[3:0]};    w_acc = 1'b1; end
            ST_CSUM: begin w_byte = {1'b0, csum_byte(w_chk)}; end
            ST_EOX:  begin w_byte = SYSEX_EOX; end
            default: begin w_tx_st = 1'b0; end
        endcase
    end

    assign w_load = w_tx_st && w_empty;

    sysex_tx_slot u_tx_slot (
        .i_clk    (sCLK_XVXENVS),
        .i_rst_n  (iRST_N),
        .i_load   (w_load),
        .i_byte   (w_byte),
        .i_acc    (w_acc),
        .i_clr    (w_start),
        .i_ready  (tx_ready),
        .o_byte   (tx_byte),
        .o_valid  (tx_valid),
        .o_empty  (w_empty),
        .o_accept (w_accept),
        .o_chk    (w_chk)
    );

    // FSM state and walk counters.
    always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= ST_IDLE;
            r_grp   <= GRP_OSC;
            r_adr   <= 7'd0;
            r_hdr   <= 2'd0;
            r_rd    <= {RD_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_grp   <= w_grp_nxt;
            r_adr   <= w_adr_nxt;
            r_hdr   <= w_hdr_nxt;
            r_rd    <= w_rd_nxt;
        end
    end

    // Parameter byte is captured on the edge that ends the read strobe; dev_id at start.
    always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
        if (!iRST_N) begin
            r_d   <= 8'h00;
            r_dev <= 7'h00;
        end else begin
            r_d   <= ((r_state == ST_RD) && (w_state_nxt == ST_HI)) ? data : r_d;
            r_dev <= w_start ? dev_id : r_dev;
        end
    end

    // Bus-side outputs registered from the next state so they align with it.
    always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
        if (!iRST_N) begin
            r_busy  <= 1'b0;
            r_adr_o <= 7'd0;
            r_sel   <= 4'b0000;
            r_read  <= 1'b0;
            r_send  <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_adr_o <= w_bus_act ? w_adr_nxt : 7'd0;
            r_sel   <= w_bus_act ? grp_onehot(w_grp_nxt) : 4'b0000;
            r_read  <= (w_state_nxt == ST_RD);
            r_send  <= w_bus_act;
        end
    end

    assign dump_busy             = r_busy;
    assign adr                   = r_adr_o;
    assign osc_sel               = r_sel[0];
    assign com_sel               = r_sel[1];
    assign m1_sel                = r_sel[2];
    assign m2_sel                = r_sel[3];
    assign read                  = r_read;
    assign sysex_data_patch_send = r_send;

endmodule

// File: tb/tb_sysex_patch_dump.sv
// Bench for sysex_patch_dump: engine memory model, SysEx stream reference model,
// handshake/bus-timing monitor, reset abort and request-filtering scenarios.
module tb_sysex_patch_dump;

    localparam int RC     = 3;
    localparam int NBYTES = 426;
    localparam int TMO    = 20000;

    logic       clk;
    logic       iRST_N;
    logic [6:0] dev_id;
    logic       dump_req;
    logic       dump_busy;
    logic [6:0] adr;
    logic       osc_sel, com_sel, m1_sel, m2_sel;
    logic       read;
    logic       sysex_data_patch_send;
    logic [7:0] data;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    sysex_patch_dump #(.READ_CYCLES(RC)) dut (
        .sCLK_XVXENVS          (clk),
        .iRST_N                (iRST_N),
        .dev_id                (dev_id),
        .dump_req              (dump_req),
        .dump_busy             (dump_busy),
        .adr                   (adr),
        .osc_sel               (osc_sel),
        .com_sel               (com_sel),
        .m1_sel                (m1_sel),
        .m2_sel                (m2_sel),
        .read                  (read),
        .sysex_data_patch_send (sysex_data_patch_send),
        .data                  (data),
        .tx_byte               (tx_byte),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Engine: latches the addressed register on the rising edge of read.
    logic [7:0] eng_mem [0:3][0:127];
    logic [7:0] eng_q = 8'h00;
    logic [1:0] sel_idx;
    assign sel_idx = m2_sel ? 2'd3 : m1_sel ? 2'd2 : com_sel ? 2'd1 : 2'd0;
    always @(posedge read) eng_q <= eng_mem[sel_idx][adr];
    assign data = sysex_data_patch_send ? eng_q : 8'h00;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic fill_mem(input bit rnd);
        for (int g = 0; g < 4; g++)
            for (int a = 0; a < 128; a++)
                eng_mem[g][a] = rnd ? 8'($urandom) : 8'h00;
    endtask

    // Reference message computed straight from the message layout.
    task automatic build_exp(input logic [6:0] dev);
        int sum;
        int len;
        int v;
        exp_q = {};
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h7D);
        exp_q.push_back({1'b0, dev});
        exp_q.push_back(8'h01);
        sum = 0;
        for (int g = 0; g < 4; g++) begin
            len = (g == 1) ? 16 : 64;
            exp_q.push_back(8'(16 + g));
            sum += 16 + g;
            for (int a = 0; a < len; a++) begin
                v = int'(eng_mem[g][a]);
                exp_q.push_back(8'(v / 16));
                exp_q.push_back(8'(v % 16));
                sum += v / 16 + v % 16;
            end
        end
        exp_q.push_back(8'((128 - sum % 128) % 128));
        exp_q.push_back(8'hF7);
    endtask

    // tx_ready driver: constant, or random with one 50-clock stall.
    bit rdy_rand  = 1'b0;
    bit hold_done = 1'b0;
    int hold_cnt  = 0;
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold_cnt > 0) begin
                tx_ready = 1'b0;
                hold_cnt--;
            end else if (rdy_rand && !hold_done && got_q.size() == 101) begin
                tx_ready  = 1'b0;
                hold_cnt  = 49;
                hold_done = 1'b1;
            end else if (rdy_rand) begin
                tx_ready = ($urandom_range(0, 3) != 0);
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    // Monitor: collects accepted bytes, checks hold-stability, read timing, one-hot sels.
    logic [3:0] sels;
    assign sels = {m2_sel, m1_sel, com_sel, osc_sel};
    logic       p_valid = 1'b0, p_ready = 1'b0, p_read = 1'b0, p_send = 1'b0, p_rst = 1'b0;
    logic [7:0] p_byte = 8'h00;
    logic [3:0] p_sels = 4'h0;
    logic [6:0] p_adr = 7'h00;
    int         rd_run = 0;
    bit         f7_pend = 1'b0;
    always @(negedge clk) begin
        if (iRST_N && p_rst) begin
            check_eq("onehot", 32'($countones(sels) <= 1), 32'd1);
            if (p_valid && !p_ready) begin
                check_eq("hold_valid", tx_valid, 1'b1);
                check_eq("hold_byte", tx_byte, p_byte);
            end
            if (f7_pend) check_eq("busy_drop", dump_busy, 1'b0);
            f7_pend = 1'b0;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_byte);
                if (tx_byte == 8'hF7) begin
                    check_eq("busy_at_f7", dump_busy, 1'b1);
                    f7_pend = 1'b1;
                end
            end
            if (read) begin
                if (rd_run == 0)
                    check_eq("pre_rd_bus", {p_read, p_send, p_sels, p_adr}, {1'b0, 1'b1, sels, adr});
                rd_run++;
            end else if (rd_run != 0) begin
                check_eq("rd_len", rd_run, RC);
                rd_run = 0;
            end
        end else begin
            rd_run  = 0;
            f7_pend = 1'b0;
        end
        p_valid = tx_valid;
        p_ready = tx_ready;
        p_byte  = tx_byte;
        p_read  = read;
        p_send  = sysex_data_patch_send;
        p_sels  = sels;
        p_adr   = adr;
        p_rst   = iRST_N;
    end

    logic [22:0] outs;
    assign outs = {dump_busy, adr, sels, read, sysex_data_patch_send, tx_byte, tx_valid};

    task automatic compare_stream();
        int n;
        int sum;
        check_eq("msg_len", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        sum = 0;
        for (int i = 4; i < got_q.size() - 1; i++) sum += int'(got_q[i]);
        check_eq("payload_sum", sum % 128, 0);
    endtask

    task automatic run_dump(input logic [6:0] dev, input bit change_dev);
        int cyc;
        build_exp(dev);
        got_q  = {};
        dev_id = dev;
        @(posedge clk); #1;
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0;
        if (change_dev) dev_id = ~dev;
        check_eq("busy_rise", dump_busy, 1'b1);
        cyc = 0;
        while (dump_busy && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("dump_done", 32'(cyc < TMO), 32'd1);
        compare_stream();
    endtask

    int          sidx [15] = '{0, 1, 2, 3, 4, 9, 10, 133, 136, 137, 295, 334, 335, 424, 425};
    logic [7:0]  sval [15] = '{8'hF0, 8'h7D, 8'h05, 8'h01, 8'h10, 8'h04, 8'h00, 8'h11,
                               8'h04, 8'h00, 8'h13, 8'h0C, 8'h05, 8'h21, 8'hF7};

    initial begin
        int cyc;
        int n_f7;
        iRST_N   = 1'b0;
        dump_req = 1'b0;
        dev_id   = 7'h00;
        fill_mem(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out", outs, 23'd0);
        iRST_N = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed patch with tx_ready held high.
        eng_mem[0][2]  = 8'h40;
        eng_mem[1][1]  = 8'h40;
        eng_mem[3][19] = 8'hC5;
        run_dump(7'h05, 1'b0);
        for (int i = 0; i < 15; i++) check_eq($sformatf("spot%0d", sidx[i]), got_q[sidx[i]], sval[i]);
        check_eq("count", got_q.size(), NBYTES);

        // Random patch, random back-pressure, dev_id changed mid-dump.
        fill_mem(1'b1);
        rdy_rand  = 1'b1;
        hold_done = 1'b0;
        run_dump(7'($urandom), 1'b1);
        rdy_rand = 1'b0;
        check_eq("stall_hit", hold_done, 1'b1);

        // Reset while reading the m1 group.
        fill_mem(1'b1);
        build_exp(7'h11);
        got_q  = {};
        dev_id = 7'h11;
        @(posedge clk); #1;
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0;
        cyc = 0;
        while (!(m1_sel && read) && cyc < TMO) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("m1_rd_seen", 32'(cyc < TMO), 32'd1);
        @(posedge clk); #2;
        iRST_N = 1'b0;
        #1;
        check_eq("rst_mid_out", outs, 23'd0);
        repeat (3) @(posedge clk);
        #1;
        n_f7 = 0;
        foreach (got_q[i]) if (got_q[i] == 8'hF7) n_f7++;
        check_eq("no_f7", n_f7, 0);
        iRST_N = 1'b1;
        run_dump(7'h11, 1'b0);

        // Requests during busy and on the F7 acceptance cycle are ignored.
        fill_mem(1'b1);
        build_exp(7'h2A);
        got_q  = {};
        dev_id = 7'h2A;
        @(posedge clk); #1;
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!(tx_valid && tx_ready && tx_byte == 8'hF7) && cyc < TMO) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("f7_offer", 32'(cyc < TMO), 32'd1);
        dump_req = 1'b1;
        @(posedge clk); #1;
        check_eq("req_at_f7", dump_busy, 1'b0);
        @(posedge clk); #1;
        dump_req = 1'b0;
        check_eq("restart", dump_busy, 1'b1);
        n_f7 = 0;
        foreach (got_q[i]) if (got_q[i] == 8'hF7) n_f7++;
        check_eq("one_msg", n_f7, 1);
        compare_stream();
        got_q = {};
        cyc   = 0;
        while (dump_busy && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("dump2_done", 32'(cyc < TMO), 32'd1);
        compare_stream();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
